// File: rtl/fifo_stream_reader.sv
// Drains the pop end of a FIFO into a registered valid/ready stream.
// A two-entry output/skid buffer keeps fifo_pop_o free of any path from ready_i.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [1:0]            occupancy_o
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  fire;

    assign valid_o     = (state_q != EMPTY);
    assign data_o      = out_q;
    assign occupancy_o = state_q;
    assign fire        = valid_o & ready_i;

    // Only registered state gates the pop, so ready_i never reaches the FIFO.
    assign fifo_pop_o = rst_ni & ~fifo_empty_i & ~flush_i & (state_q != TWO);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        if (flush_i) begin
            state_d = EMPTY;
            out_d   = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (fifo_pop_o) begin
                        out_d   = fifo_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (fifo_pop_o && fire) begin
                        out_d = fifo_data_i;
                    end else if (fifo_pop_o) begin
                        skid_d  = fifo_data_i;
                        state_d = TWO;
                    end else if (fire) begin
                        // out_q keeps its stale value; valid_o already masks it.
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (fire) begin
                        out_d   = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the data registers
    // are reset too because data_o must read zero out of reset and after a flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

`ifndef SYNTHESIS
    ap_pop_not_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_pop_o |-> !fifo_empty_i);
    ap_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o && !ready_i && !flush_i |=> valid_o && $stable(data_o));
    ap_occ_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        occupancy_o != 2'd3);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue model of the FIFO and of the
// buffered entries is checked every cycle by an independent monitor.
module tb_fifo_stream_reader;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_pop_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          ready_i;
    logic [1:0]    occupancy_o;

    fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .fifo_pop_o  (fifo_pop_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ready_i     (ready_i),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    // Source FIFO contents and the entries the reader should currently hold.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out = '0;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            delivered = 0;

    // Stimulus knobs, applied by cycle().
    logic rdy = 1'b0;
    logic fl = 1'b0;
    logic gate_empty = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive inputs just after the rising edge, return just after the falling edge.
    task automatic cycle();
        @(posedge clk_i);
        #1;
        fifo_empty_i = gate_empty || (src_q.size() == 0);
        fifo_data_i  = (src_q.size() > 0) ? src_q[0] : '0;
        ready_i      = rdy;
        flush_i      = fl;
        @(negedge clk_i);
        #1;
    endtask

    // Monitor: compare against the model, then advance the model to the next edge.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            automatic int  sz      = exp_q.size();
            automatic logic exp_pop = !fifo_empty_i && !flush_i && (sz < 2);
            automatic logic fire_m  = (sz > 0) && ready_i;
            check("pop", fifo_pop_o, exp_pop);
            if (fifo_empty_i) check("pop_while_empty", fifo_pop_o, 1'b0);
            check("valid", valid_o, sz > 0);
            check("occupancy", occupancy_o, sz[1:0]);
            if (sz > 0) check(fire_m && !flush_i ? "fire_data" : "hold_data", data_o, exp_q[0]);
            else        check("idle_data", data_o, last_out);

            if (flush_i) begin
                exp_q.delete();
                src_q.delete();
                last_out = '0;
            end else begin
                if (fire_m) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
                if (exp_pop) exp_q.push_back(src_q.pop_front());
                if (exp_q.size() > 0) last_out = exp_q[0];
            end
        end
    end

    initial begin
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        fifo_empty_i = 1'b0;
        fifo_data_i  = 32'hDEAD_BEEF;
        ready_i      = 1'b0;
        #12;
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", data_o, '0);
        check("rst_occ", occupancy_o, 2'd0);
        check("rst_pop", fifo_pop_o, 1'b0);
        fifo_empty_i = 1'b1;
        @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Single element latency.
        src_q.push_back(32'hA1);
        rdy = 1'b1;
        cycle(); check("t1_pop_c1", fifo_pop_o, 1'b1);
        cycle(); check("t1_valid_c2", valid_o, 1'b1); check("t1_data_c2", data_o, 32'hA1);
        cycle(); check("t1_valid_c3", valid_o, 1'b0);

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 8; i++) src_q.push_back(32'h10 + i);
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (i < 8) check("t2_pop", fifo_pop_o, 1'b1);
            if (i >= 1) begin
                check("t2_data", data_o, 32'h10 + i - 1);
                check("t2_occ", occupancy_o, 2'd1);
            end
        end
        cycle();

        // Backpressure into the skid entry, then resume.
        src_q.push_back(32'h20); src_q.push_back(32'h21); src_q.push_back(32'h22);
        rdy = 1'b1; cycle();
        rdy = 1'b0; cycle(); check("t3_data_c2", data_o, 32'h20);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("t3_occ_two", occupancy_o, 2'd2);
            check("t3_pop_two", fifo_pop_o, 1'b0);
            check("t3_data_held", data_o, 32'h20);
        end
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3_resume_valid", valid_o, 1'b1);
            check("t3_resume_data", data_o, 32'h20 + i);
        end
        cycle(); check("t3_drained", valid_o, 1'b0);

        // Flush while holding two entries.
        src_q.push_back(32'h30); src_q.push_back(32'h31); src_q.push_back(32'h32);
        rdy = 1'b0; cycle(); cycle();
        rdy = 1'b1; fl = 1'b1;
        cycle(); check("t5_occ_before", occupancy_o, 2'd2); check("t5_pop_flush", fifo_pop_o, 1'b0);
        fl = 1'b0;
        cycle();
        check("t5_valid", valid_o, 1'b0);
        check("t5_occ", occupancy_o, 2'd0);
        check("t5_data", data_o, '0);

        // Asynchronous reset while in ONE.
        src_q.push_back(32'h40);
        rdy = 1'b0; cycle(); cycle();
        check("t6_in_one", occupancy_o, 2'd1);
        rst_ni = 1'b0;
        exp_q.delete();
        last_out = '0;
        src_q.push_back(32'h41);
        fifo_empty_i = 1'b0;
        fifo_data_i  = 32'h41;
        #1;
        check("t6_valid", valid_o, 1'b0);
        check("t6_pop", fifo_pop_o, 1'b0);
        check("t6_occ", occupancy_o, 2'd0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        rdy = 1'b1;
        cycle(); check("t6_resume_valid", valid_o, 1'b1); check("t6_resume_data", data_o, 32'h41);
        cycle(); check("t6_resume_idle", valid_o, 1'b0);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(1, 0) == 1 && src_q.size() < 8) src_q.push_back($urandom);
            rdy        = $urandom_range(1, 0) == 1;
            gate_empty = $urandom_range(3, 0) == 0;
            fl         = $urandom_range(63, 0) == 0;
            cycle();
        end
        rdy = 1'b1; gate_empty = 1'b0; fl = 1'b0;
        for (int i = 0; i < 40 && (src_q.size() > 0 || exp_q.size() > 0); i++) cycle();
        cycle();
        check("drain_valid", valid_o, 1'b0);
        check("drain_occ", occupancy_o, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drains the pop end of a generic FIFO (empty flag, combinational head data, pop strobe) and presents the data as a registered valid/ready stream.
- Uses a 2-entry output/skid buffer, so the fifo pop strobe has no combinational path from downstream ready_i, while still sustaining one transfer per cycle.
- Sits between any queue built from the fifo block and a pipeline consumer, e.g. issue or writeback stages.

Parameters:
- DATA_WIDTH, 32, width of each FIFO element and of the output stream data.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous reset, active low.
- flush_i  input  1  synchronous flush; empties the buffer.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_data_i  input  DATA_WIDTH  FIFO head data; valid whenever fifo_empty_i=0.
- fifo_pop_o  output  1  pops the FIFO head this cycle.
- valid_o  output  1  output stream data valid.
- data_o  output  DATA_WIDTH  output stream data.
- ready_i  input  1  consumer accepts data_o this cycle.
- occupancy_o  output  2  entries held: 0, 1 or 2.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active low.
- Reset values:
  - state=EMPTY; out_q=0; skid_q=0.
  - valid_o=0, data_o=0, occupancy_o=0.
  - fifo_pop_o=0 while rst_ni=0.
- States:
  - EMPTY (occupancy 0).
  - ONE (out_q valid).
  - TWO (out_q and skid_q valid).
- Output signals:
  - valid_o = (state!=EMPTY), registered.
  - data_o = out_q.
  - fire = valid_o & ready_i.
- Pop strobe: fifo_pop_o = ~fifo_empty_i & ~flush_i & (state!=TWO).
  - Depends only on fifo_empty_i, flush_i and registered state.
  - Never depends on ready_i.
  - Never asserted while fifo_empty_i=1.
- fifo_data_i is sampled in the same cycle fifo_pop_o=1.
- Transitions when flush_i=0 (pop = fifo_pop_o):
  - EMPTY, pop: out_q<=fifo_data_i -> ONE.
  - EMPTY, no pop: stay EMPTY.
  - ONE, pop & fire: out_q<=fifo_data_i, stay ONE (full throughput).
  - ONE, pop & ~fire: skid_q<=fifo_data_i -> TWO.
  - ONE, ~pop & fire: -> EMPTY; out_q keeps its stale value.
  - ONE, ~pop & ~fire: hold.
  - TWO, fire: out_q<=skid_q -> ONE. No pop possible in TWO.
  - TWO, ~fire: hold.
- Latency: element at FIFO head with empty low in cycle N appears on valid_o/data_o in cycle N+1, when state is EMPTY or ONE-with-fire.
- Stream rules:
  - Once valid_o=1, valid_o and data_o stay stable until fire.
  - Order is preserved strictly FIFO.
  - No element is dropped or duplicated.
- Flush:
  - flush_i=1 takes priority over every transition.
  - Next cycle: state=EMPTY, out_q=0, skid_q=0.
  - fifo_pop_o=0 during the flush cycle.
  - fire during the flush cycle is ignored; the data is discarded.
  - The fifo itself is flushed by the same signal externally.
- Reset mid-operation: immediate return to the reset values; in-flight entries are lost.
- occupancy_o encodes the state: EMPTY=0, ONE=1, TWO=2. Value 3 is never driven.
- Simulation assertions, excluded under SYNTHESIS:
  - fifo_pop_o -> ~fifo_empty_i.
  - valid_o & ~ready_i |=> valid_o & $stable(data_o).
  - occupancy_o != 3.

Test Plan:
- Reset, then FIFO holding 0xA1: empty low in cycle 1, ready_i=1 -> fifo_pop_o=1 in cycle 1; valid_o=1, data_o=0xA1 in cycle 2; valid_o=0 in cycle 3.
- Back-to-back stream 0x10..0x17 with ready_i=1 throughout -> one pop per cycle; data_o=0x10..0x17 on consecutive cycles; occupancy_o stays 1.
- Stream 0x20,0x21,0x22, ready_i=0 from cycle 2 -> occupancy_o=2; fifo_pop_o=0 while TWO; data_o=0x20 held stable. Raising ready_i then delivers 0x20,0x21,0x22 in order, no gaps once resumed.
- Random ready_i (50%) and random fifo_empty_i over 10k cycles against a scoreboard -> exact in-order match, no loss/duplication; fifo_pop_o never asserted while fifo_empty_i=1.
- In TWO holding 0x30,0x31, assert flush_i for 1 cycle with ready_i=1 -> next cycle valid_o=0, occupancy_o=0, data_o=0; fifo_pop_o=0 during flush; 0x30 is not counted as delivered.
- Assert rst_ni=0 asynchronously mid-cycle while in ONE -> valid_o, fifo_pop_o and occupancy_o drop to 0 before the next clock edge; normal operation resumes after release.
